// File: rtl/spirose_drv_pkg.sv
// Shared constants and types for the LED-driver stream path.
// The framebuffer and driver_stream_rx both size themselves from this package.
package spirose_drv_pkg;

    localparam int MULTIPLEXING   = 8;
    localparam int LED_PER_DRIVER = 16;
    localparam int POKER_MODE     = 9;
    localparam int NB_DRIVERS     = 30;
    localparam int COLORS         = 3;
    localparam int SYNC_TO_DATA   = 2;
    localparam int LATGS_LEN      = 3;

    localparam int COLOR_W = $clog2(COLORS);
    localparam int LED_W   = $clog2(LED_PER_DRIVER);
    localparam int PLANE_W = $clog2(POKER_MODE);
    localparam int COL_W   = $clog2(MULTIPLEXING);
    localparam int ALIGN_W = (SYNC_TO_DATA > 1) ? $clog2(SYNC_TO_DATA) : 1;

    typedef logic [NB_DRIVERS-1:0] drv_lanes_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIGN  = 2'd1,
        STREAM = 2'd2
    } rx_state_t;

endpackage

// File: rtl/driver_stream_rx_beat_counter.sv
// Beat position cascade for one slice: color (innermost), led, plane, col (outermost).
// Planes are sent MSB first, so the plane counter runs up while the plane index runs down.
module stream_beat_counter
    import spirose_drv_pkg::*;
(
    input  logic             clk_33,
    input  logic             nrst,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [COL_W-1:0] col_o,
    output logic             plane_last_o,
    output logic             col_last_o,
    output logic             slice_last_o,
    output logic             lat_window_o
);

    localparam logic [COLOR_W-1:0] COLOR_LAST = COLOR_W'(COLORS - 1);
    localparam logic [LED_W-1:0]   LED_LAST   = LED_W'(LED_PER_DRIVER - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(POKER_MODE - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(MULTIPLEXING - 1);

    logic [COLOR_W-1:0] color_q, color_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [PLANE_W-1:0] plane_cnt_q, plane_cnt_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               led_end;
    logic               final_plane;

    // plane_cnt counts sent planes; the last one sent is bit plane 0 (the LATGS plane)
    assign led_end      = (led_q == LED_LAST);
    assign final_plane  = (plane_cnt_q == PLANE_LAST);
    assign plane_last_o = (color_q == COLOR_LAST) && led_end;
    assign col_last_o   = plane_last_o && final_plane;
    assign slice_last_o = col_last_o && (col_q == COL_LAST);
    assign lat_window_o = led_end && final_plane;
    assign col_o        = col_q;

    always_comb begin
        color_d     = color_q;
        led_d       = led_q;
        plane_cnt_d = plane_cnt_q;
        col_d       = col_q;
        if (clear_i) begin
            color_d     = '0;
            led_d       = '0;
            plane_cnt_d = '0;
            col_d       = '0;
        end else if (advance_i) begin
            if (color_q == COLOR_LAST) begin
                color_d = '0;
                if (led_end) begin
                    led_d = '0;
                    if (final_plane) begin
                        plane_cnt_d = '0;
                        col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                    end else begin
                        plane_cnt_d = plane_cnt_q + 1'b1;
                    end
                end else begin
                    led_d = led_q + 1'b1;
                end
            end else begin
                color_d = color_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_33) begin
        if (!nrst) begin
            color_q     <= '0;
            led_q       <= '0;
            plane_cnt_q <= '0;
            col_q       <= '0;
        end else begin
            color_q     <= color_d;
            led_q       <= led_d;
            plane_cnt_q <= plane_cnt_d;
            col_q       <= col_d;
        end
    end

endmodule

// File: rtl/driver_stream_rx.sv
// Converts the framebuffer's 30-lane bit-serial stream into LED-driver SIN/SCLK/LAT
// plus the one-hot column select.
//   state  | meaning
//   IDLE   | waiting for sync, outputs quiet, counters at 0
//   ALIGN  | sync seen, counting down to the first data beat
//   STREAM | every cycle is a beat; counters walk the slice
module driver_stream_rx
    import spirose_drv_pkg::*;
(
    input  logic                    clk_33,
    input  logic                    nrst,
    input  drv_lanes_t              data_i,
    input  logic                    sync_i,
    output drv_lanes_t              drv_sin_o,
    output logic                    drv_sclk_en_o,
    output logic                    drv_lat_o,
    output logic [MULTIPLEXING-1:0] mux_sel_o,
    output logic                    slice_done_o,
    output logic                    frame_err_o
);

    localparam logic [ALIGN_W-1:0] ALIGN_INIT = ALIGN_W'(SYNC_TO_DATA - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(MULTIPLEXING - 1);

    rx_state_t               state_q, state_d;
    logic [ALIGN_W-1:0]      align_cnt_q, align_cnt_d;
    drv_lanes_t              drv_sin_q;
    logic                    drv_sclk_en_q;
    logic                    drv_lat_q;
    logic [MULTIPLEXING-1:0] mux_sel_q;
    logic                    slice_done_q;
    logic                    frame_err_q;
    logic                    col_end_q;
    logic [COL_W-1:0]        col_end_idx_q;

    logic             beat;
    logic             abort;
    logic [COL_W-1:0] col;
    logic             plane_last;
    logic             col_last;
    logic             slice_last;
    logic             lat_window;

    assign beat  = (state_q == STREAM);
    // A sync on the final beat of a slice is a clean back-to-back start, not an error
    assign abort = beat && sync_i && !slice_last;

    stream_beat_counter u_beat_counter (
        .clk_33       (clk_33),
        .nrst         (nrst),
        .clear_i      (sync_i || !beat),
        .advance_i    (beat),
        .col_o        (col),
        .plane_last_o (plane_last),
        .col_last_o   (col_last),
        .slice_last_o (slice_last),
        .lat_window_o (lat_window)
    );

    always_comb begin
        state_d     = state_q;
        align_cnt_d = align_cnt_q;
        case (state_q)
            IDLE: begin
                if (sync_i) begin
                    state_d     = ALIGN;
                    align_cnt_d = ALIGN_INIT;
                end
            end
            ALIGN: begin
                if (sync_i) begin
                    align_cnt_d = ALIGN_INIT;
                end else if (align_cnt_q == '0) begin
                    state_d = STREAM;
                end else begin
                    align_cnt_d = align_cnt_q - 1'b1;
                end
            end
            STREAM: begin
                if (sync_i) begin
                    state_d     = ALIGN;
                    align_cnt_d = ALIGN_INIT;
                end else if (slice_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                align_cnt_d = '0;
            end
        endcase
    end

    // Column select and slice_done trail the column's last beat by one cycle,
    // so they change exactly when LATGS drops at the pins.
    always_ff @(posedge clk_33) begin
        if (!nrst) begin
            state_q       <= IDLE;
            align_cnt_q   <= '0;
            drv_sin_q     <= '0;
            drv_sclk_en_q <= 1'b0;
            drv_lat_q     <= 1'b0;
            mux_sel_q     <= '0;
            slice_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            col_end_q     <= 1'b0;
            col_end_idx_q <= '0;
        end else begin
            state_q       <= state_d;
            align_cnt_q   <= align_cnt_d;
            drv_sin_q     <= beat ? data_i : '0;
            drv_sclk_en_q <= beat;
            drv_lat_q     <= beat && (plane_last || lat_window) && !abort;
            col_end_q     <= beat && col_last && !abort;
            col_end_idx_q <= col;
            slice_done_q  <= col_end_q && (col_end_idx_q == COL_LAST);
            frame_err_q   <= frame_err_q || abort;
            if (col_end_q) begin
                mux_sel_q <= MULTIPLEXING'(1) << col_end_idx_q;
            end
        end
    end

    assign drv_sin_o     = drv_sin_q;
    assign drv_sclk_en_o = drv_sclk_en_q;
    assign drv_lat_o     = drv_lat_q;
    assign mux_sel_o     = mux_sel_q;
    assign slice_done_o  = slice_done_q;
    assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_driver_stream_rx.sv
// Bench for driver_stream_rx: random lane data against a slice-position reference model.
module tb_driver_stream_rx;
    import spirose_drv_pkg::*;

    localparam logic [29:0] PAT = 30'h2AAAAAAA;

    logic        clk_33 = 1'b0;
    logic        nrst   = 1'b0;
    logic        sync_i = 1'b0;
    logic [29:0] data_i = '0;
    logic [29:0] drv_sin_o;
    logic        drv_sclk_en_o;
    logic        drv_lat_o;
    logic [7:0]  mux_sel_o;
    logic        slice_done_o;
    logic        frame_err_o;

    always #15 clk_33 = ~clk_33;

    driver_stream_rx dut (
        .clk_33        (clk_33),
        .nrst          (nrst),
        .data_i        (data_i),
        .sync_i        (sync_i),
        .drv_sin_o     (drv_sin_o),
        .drv_sclk_en_o (drv_sclk_en_o),
        .drv_lat_o     (drv_lat_o),
        .mux_sel_o     (mux_sel_o),
        .slice_done_o  (slice_done_o),
        .frame_err_o   (frame_err_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat_seen = 0;
    int sclk_seen = 0;
    int first_sclk = -1;

    // Reference model: slice progress as a plain beat index 0..3455
    int          m_mode = 0;   // 0 idle, 1 waiting for first beat, 2 streaming
    int          m_wait = 0;
    int          m_k = 0;
    logic        m_pend = 1'b0;
    int          m_pend_col = 0;
    logic [29:0] e_sin = '0;
    logic        e_sclk = 1'b0;
    logic        e_lat = 1'b0;
    logic [7:0]  e_mux = '0;
    logic        e_done = 1'b0;
    logic        e_err = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Per column: one WRTGS beat at the end of each of the first 8 planes, then 3 LATGS beats
    function automatic logic lat_of(input int k);
        int off;
        off = k % 432;
        return ((off < 384) && (off % 48 == 47)) || (off >= 429);
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic [29:0] d);
        logic in_beat, last, abort;
        if (!r) begin
            e_sin = '0; e_sclk = 1'b0; e_lat = 1'b0; e_mux = '0; e_done = 1'b0; e_err = 1'b0;
            m_mode = 0; m_wait = 0; m_k = 0; m_pend = 1'b0;
        end else begin
            e_done = m_pend && (m_pend_col == 7);
            if (m_pend) e_mux = 8'(1) << m_pend_col;
            m_pend  = 1'b0;
            in_beat = (m_mode == 2);
            last    = in_beat && (m_k == 3455);
            abort   = in_beat && s && !last;
            e_sin   = in_beat ? d : '0;
            e_sclk  = in_beat;
            e_lat   = in_beat && lat_of(m_k) && !abort;
            if (in_beat && !abort && (m_k % 432 == 431)) begin
                m_pend = 1'b1;
                m_pend_col = m_k / 432;
            end
            if (abort) e_err = 1'b1;
            if (s) begin
                m_mode = 1; m_wait = 2;
            end else if (m_mode == 1) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_mode = 2; m_k = 0;
                end
            end else if (m_mode == 2) begin
                if (last) m_mode = 0;
                else m_k++;
            end
        end
    endtask

    task automatic step(input logic s, input logic [29:0] d, input logic r);
        sync_i = s; data_i = d; nrst = r;
        @(posedge clk_33);
        cyc++;
        model_edge(r, s, d);
        #1;
        check_val("sin", 32'(drv_sin_o), 32'(e_sin));
        check_val("sclk_en", 32'(drv_sclk_en_o), 32'(e_sclk));
        check_val("lat", 32'(drv_lat_o), 32'(e_lat));
        check_val("mux_sel", 32'(mux_sel_o), 32'(e_mux));
        check_val("slice_done", 32'(slice_done_o), 32'(e_done));
        check_val("frame_err", 32'(frame_err_o), 32'(e_err));
        if (drv_lat_o) lat_seen++;
        if (drv_sclk_en_o) begin
            sclk_seen++;
            if (first_sclk < 0) first_sclk = cyc;
        end
    endtask

    // Random data until slice_done, stop_cyc, or the end of a reset pulse
    task automatic run(input int sync_cyc, input int rst_cyc, input int stop_cyc,
                       input int pat_cyc, output int t_done);
        t_done = -1;
        while (t_done < 0 && cyc < stop_cyc) begin
            logic [29:0] d;
            d = 30'($urandom);
            if (cyc + 1 == pat_cyc) d = PAT;
            step(cyc + 1 == sync_cyc, d, cyc + 1 != rst_cyc);
            if (cyc == pat_cyc) check_val("lane_pat", 32'(drv_sin_o), 32'(PAT));
            if (cyc == sync_cyc && e_err) begin
                check_val("err_next", 32'(frame_err_o), 32'd1);
                check_val("lat_abort", 32'(drv_lat_o), 32'd0);
            end
            if (slice_done_o) t_done = cyc;
        end
    endtask

    task automatic expect_slice(input string tag, input int t0, input int t_done);
        check_val({tag, "_seen"}, 32'(t_done >= 0), 32'd1);
        check_val({tag, "_at"}, 32'(t_done - t0), 32'd3459);
        check_val({tag, "_mux"}, 32'(mux_sel_o), 32'h80);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, td;

        // Reset and a clean slice
        repeat (3) step(1'b0, 30'($urandom), 1'b0);
        check_val("rst_mux", 32'(mux_sel_o), 32'h0);
        step(1'b0, 30'($urandom), 1'b1);
        lat_seen = 0; sclk_seen = 0; first_sclk = -1;
        step(1'b1, 30'($urandom), 1'b1);
        t0 = cyc;
        run(-1, -1, cyc + 4000, t0 + 8, td);
        expect_slice("slice1", t0, td);
        check_val("first_sclk", 32'(first_sclk - t0), 32'd3);
        check_val("sclk_beats", 32'(sclk_seen), 32'd3456);
        check_val("lat_beats", 32'(lat_seen), 32'd88);
        repeat (5) step(1'b0, 30'($urandom), 1'b1);
        check_val("mux_hold", 32'(mux_sel_o), 32'h80);

        // sync restarting ALIGN, then back-to-back slices via sync on the final beat
        step(1'b1, 30'($urandom), 1'b1);
        step(1'b1, 30'($urandom), 1'b1);
        t0 = cyc;
        lat_seen = 0;
        run(t0 + 3458, -1, cyc + 4000, -1, td);
        expect_slice("slice2", t0, td);
        t1 = t0 + 3458;
        run(-1, -1, cyc + 4000, -1, td);
        expect_slice("slice3", t1, td);
        check_val("b2b_lat", 32'(lat_seen), 32'd176);
        check_val("b2b_err", 32'(frame_err_o), 32'd0);

        // sync mid-stream at beat 1000
        repeat (3) step(1'b0, 30'($urandom), 1'b1);
        step(1'b1, 30'($urandom), 1'b1);
        t0 = cyc;
        t1 = t0 + 3 + 1000;
        lat_seen = 0;
        run(t1, -1, cyc + 8000, -1, td);
        expect_slice("restart", t1, td);
        check_val("restart_lat", 32'(lat_seen), 32'd112);
        check_val("err_sticky", 32'(frame_err_o), 32'd1);

        // reset pulse at beat 2000, then a clean slice
        step(1'b1, 30'($urandom), 1'b1);
        t0 = cyc;
        run(-1, t0 + 3 + 2000, t0 + 3 + 2000, -1, td);
        check_val("rst_sclk", 32'(drv_sclk_en_o), 32'd0);
        check_val("rst_lat", 32'(drv_lat_o), 32'd0);
        check_val("rst_mux2", 32'(mux_sel_o), 32'h0);
        check_val("rst_err", 32'(frame_err_o), 32'd0);
        repeat (4) step(1'b0, 30'($urandom), 1'b1);
        check_val("rst_idle", 32'(drv_sclk_en_o), 32'd0);
        lat_seen = 0;
        step(1'b1, 30'($urandom), 1'b1);
        t0 = cyc;
        run(-1, -1, cyc + 4000, -1, td);
        expect_slice("post_rst", t0, td);
        check_val("post_rst_lat", 32'(lat_seen), 32'd88);
        check_val("post_rst_err", 32'(frame_err_o), 32'd0);

        // Random sync traffic
        for (int i = 0; i < 5000; i++) begin
            step($urandom_range(0, 1499) == 0, 30'($urandom), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
